// File: rtl/w_route_tracker_pkg.sv
// Shared types for the W-channel route tracker.
// The len field is stored only when W_ROUTE_LEN_CHECK_EN is defined.
package w_route_tracker_pkg;
  localparam int BEAT_W = 8;
  // Widest target index the entry can carry; the tracker zero-extends LOG_N into it.
  localparam int TGT_W  = 8;

  typedef struct packed {
    logic [TGT_W-1:0]  target;
`ifdef W_ROUTE_LEN_CHECK_EN
    logic [BEAT_W-1:0] len;
`endif
  } w_route_ent_t;
endpackage

// File: rtl/w_route_fifo.sv
// Per-master FIFO of outstanding AW routing entries.
// The head reads as zero while empty, so the route output is clean out of reset.
module w_route_fifo
  import w_route_tracker_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic         i_pop,
  input  w_route_ent_t i_ent,
  output w_route_ent_t o_head,
  output logic         o_full,
  output logic         o_empty
);
  localparam int PTR_W = $clog2(DEPTH);

  w_route_ent_t     r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd;
  logic [PTR_W-1:0] r_wr;
  logic [PTR_W:0]   r_cnt;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_cnt == (PTR_W+1)'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign w_pop   = i_pop & ~o_empty;
  // A pop in the same edge frees a slot, so a push is still taken when full.
  assign w_push  = i_push & (~o_full | w_pop);
  assign o_head  = o_empty ? '0 : r_mem[r_rd];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_ent;
  end
endmodule

// File: rtl/w_route_tracker.sv
// Tracks accepted AW bursts per master and routes/gates the W channel to match.
// Optional wlast/length checker compiled with W_ROUTE_LEN_CHECK_EN.
module w_route_tracker
  import w_route_tracker_pkg::*;
#(
  parameter int M     = 2,
  parameter int N     = 2,
  parameter int DEPTH = 4,
  parameter int LOG_N = (N > 1) ? $clog2(N) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [M-1:0]      aw_hs_i,
  input  logic [LOG_N-1:0]  aw_target_i [M],
  input  logic [BEAT_W-1:0] aw_len_i    [M],
  input  logic [M-1:0]      m_wvalid_i,
  input  logic [M-1:0]      m_wlast_i,
  input  logic [M-1:0]      m_wready_i,
  output logic [M-1:0]      w_valid_o,
  output logic [LOG_N-1:0]  w_target_o  [M],
  output logic [M-1:0]      aw_stall_o,
  output logic [M-1:0]      len_err_o
);
  for (genvar m = 0; m < M; m++) begin : g_mst
    w_route_ent_t w_in;
    w_route_ent_t w_head;
    logic         w_empty;
    logic         w_acc;

    always_comb begin
      w_in        = '0;
      w_in.target = TGT_W'(aw_target_i[m]);
`ifdef W_ROUTE_LEN_CHECK_EN
      w_in.len    = aw_len_i[m];
`endif
    end

    // Beats with no recorded AW are held off at the arbiter, never dropped.
    assign w_valid_o[m]  = m_wvalid_i[m] & ~w_empty;
    assign w_acc         = w_valid_o[m] & m_wready_i[m];
    assign w_target_o[m] = w_head.target[LOG_N-1:0];

    w_route_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (aw_hs_i[m]),
      .i_pop   (w_acc & m_wlast_i[m]),
      .i_ent   (w_in),
      .o_head  (w_head),
      .o_full  (aw_stall_o[m]),
      .o_empty (w_empty)
    );

`ifdef W_ROUTE_LEN_CHECK_EN
    logic [BEAT_W-1:0] r_beats;
    logic              r_err;

    // r_beats holds beats already accepted, so the last beat is index len.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_beats <= '0;
        r_err   <= 1'b0;
      end else if (w_acc) begin
        r_beats <= m_wlast_i[m] ? '0 : r_beats + 1'b1;
        if (m_wlast_i[m] != (r_beats == w_head.len)) r_err <= 1'b1;
      end
    end
    assign len_err_o[m] = r_err;
`else
    assign len_err_o[m] = 1'b0;
`endif
  end
endmodule

// File: tb/tb_w_route_tracker.sv
// Bench for w_route_tracker: directed scenarios plus random traffic vs a queue model.
module tb_w_route_tracker;
  localparam int M = 2, N = 2, DEPTH = 4, LOG_N = 1;
`ifdef W_ROUTE_LEN_CHECK_EN
  localparam bit LEN_EN = 1'b1;
`else
  localparam bit LEN_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [M-1:0]     aw_hs_i;
  logic [LOG_N-1:0] aw_target_i [M];
  logic [7:0]       aw_len_i    [M];
  logic [M-1:0]     m_wvalid_i, m_wlast_i, m_wready_i;
  logic [M-1:0]     w_valid_o;
  logic [LOG_N-1:0] w_target_o  [M];
  logic [M-1:0]     aw_stall_o, len_err_o;

  w_route_tracker #(.M(M), .N(N), .DEPTH(DEPTH), .LOG_N(LOG_N)) dut (
    .clk(clk), .rst(rst), .aw_hs_i(aw_hs_i), .aw_target_i(aw_target_i),
    .aw_len_i(aw_len_i), .m_wvalid_i(m_wvalid_i), .m_wlast_i(m_wlast_i),
    .m_wready_i(m_wready_i), .w_valid_o(w_valid_o), .w_target_o(w_target_o),
    .aw_stall_o(aw_stall_o), .len_err_o(len_err_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int q_tgt [M][$];
  int q_len [M][$];
  int beats [M];
  bit err   [M];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    aw_hs_i = '0; m_wvalid_i = '0; m_wlast_i = '0; m_wready_i = '0;
    for (int m = 0; m < M; m++) begin
      aw_target_i[m] = '0;
      aw_len_i[m]    = '0;
    end
  endtask

  // Compare outputs against the model mid-cycle, then advance the model on the edge.
  task automatic cycle();
    @(negedge clk);
    for (int m = 0; m < M; m++) begin
      bit ne;
      ne = (q_tgt[m].size() != 0);
      chk($sformatf("w_valid[%0d]", m), 32'(w_valid_o[m]), 32'(m_wvalid_i[m] & ne));
      chk($sformatf("aw_stall[%0d]", m), 32'(aw_stall_o[m]), 32'(q_tgt[m].size() == DEPTH));
      if (ne) chk($sformatf("w_target[%0d]", m), 32'(w_target_o[m]), q_tgt[m][0]);
      chk($sformatf("len_err[%0d]", m), 32'(len_err_o[m]), 32'(LEN_EN & err[m]));
    end
    @(posedge clk);
    for (int m = 0; m < M; m++) begin
      if (rst) begin
        q_tgt[m].delete(); q_len[m].delete();
        beats[m] = 0; err[m] = 0;
      end else begin
        bit acc, popd, full;
        full = (q_tgt[m].size() == DEPTH);
        acc  = m_wvalid_i[m] && (q_tgt[m].size() != 0) && m_wready_i[m];
        popd = acc && m_wlast_i[m];
        if (acc) begin
          if (m_wlast_i[m] ? (beats[m] != q_len[m][0]) : (beats[m] == q_len[m][0])) err[m] = 1;
          beats[m] = m_wlast_i[m] ? 0 : (beats[m] + 1) % 256;
        end
        if (popd) begin
          void'(q_tgt[m].pop_front());
          void'(q_len[m].pop_front());
        end
        if (aw_hs_i[m] && (!full || popd)) begin
          q_tgt[m].push_back(int'(aw_target_i[m]));
          q_len[m].push_back(int'(aw_len_i[m]));
        end
      end
    end
    #1;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    cycle(); cycle();
    rst = 1'b0;
    @(negedge clk);
    for (int m = 0; m < M; m++) begin
      chk($sformatf("rst_target[%0d]", m), 32'(w_target_o[m]), 0);
      chk($sformatf("rst_stall[%0d]", m), 32'(aw_stall_o[m]), 0);
    end
    @(posedge clk); #1;

    // Single 4-beat burst on master 0 routed to slave 1
    aw_hs_i[0] = 1'b1; aw_target_i[0] = 1'b1; aw_len_i[0] = 8'd3;
    cycle();
    idle();
    m_wvalid_i[0] = 1'b1; m_wready_i[0] = 1'b1;
    for (int b = 0; b < 4; b++) begin
      m_wlast_i[0] = (b == 3);
      cycle();
    end
    m_wlast_i[0] = 1'b0;
    cycle();
    idle();

    // W ahead of AW on master 1 is held off until the AW lands
    m_wvalid_i[1] = 1'b1;
    cycle(); cycle(); cycle();
    aw_hs_i[1] = 1'b1; aw_target_i[1] = 1'b0;
    cycle();
    aw_hs_i[1] = 1'b0;
    @(negedge clk);
    chk("w_before_aw_valid", 32'(w_valid_o[1]), 1);
    @(posedge clk); #1;
    m_wready_i[1] = 1'b1; m_wlast_i[1] = 1'b1;
    cycle();
    idle();

    // Fill master 0, push while full, then push with a simultaneous pop
    for (int i = 0; i < DEPTH; i++) begin
      aw_hs_i[0] = 1'b1; aw_target_i[0] = LOG_N'(i & 1);
      cycle();
    end
    aw_target_i[0] = 1'b1;
    cycle();
    m_wvalid_i[0] = 1'b1; m_wready_i[0] = 1'b1; m_wlast_i[0] = 1'b1; aw_target_i[0] = 1'b0;
    cycle();
    idle();
    @(negedge clk);
    chk("full_after_swap", 32'(aw_stall_o[0]), 1);
    @(posedge clk); #1;
    m_wvalid_i[0] = 1'b1; m_wready_i[0] = 1'b1; m_wlast_i[0] = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) cycle();
    idle();

    // Pointer wrap with alternating single-beat bursts
    for (int i = 0; i < 10; i++) begin
      aw_hs_i[0] = 1'b1; aw_target_i[0] = LOG_N'(i & 1);
      m_wvalid_i[0] = (i > 1); m_wready_i[0] = 1'b1; m_wlast_i[0] = 1'b1;
      cycle();
    end
    idle();
    m_wvalid_i[0] = 1'b1; m_wready_i[0] = 1'b1; m_wlast_i[0] = 1'b1;
    cycle(); cycle(); cycle();
    idle();

    // Random traffic with occasional reset
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 60) == 0);
      for (int m = 0; m < M; m++) begin
        aw_hs_i[m]     = ($urandom_range(0, 2) == 0);
        aw_target_i[m] = LOG_N'($urandom_range(0, 1));
        aw_len_i[m]    = 8'($urandom_range(0, 3));
        m_wvalid_i[m]  = ($urandom_range(0, 3) != 0);
        m_wready_i[m]  = ($urandom_range(0, 2) != 0);
        m_wlast_i[m]   = ($urandom_range(0, 2) == 0);
      end
      cycle();
    end
    idle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;

`ifdef W_ROUTE_LEN_CHECK_EN
    // Early wlast on a two-beat burst
    aw_hs_i[0] = 1'b1; aw_target_i[0] = 1'b1; aw_len_i[0] = 8'd1;
    cycle();
    idle();
    m_wvalid_i[0] = 1'b1; m_wready_i[0] = 1'b1; m_wlast_i[0] = 1'b1;
    cycle();
    idle();
    cycle(); cycle();
    @(negedge clk);
    chk("len_err_sticky", 32'(len_err_o[0]), 1);
    @(posedge clk); #1;
`endif

    // Reset in the middle of a burst abandons it
    aw_hs_i[0] = 1'b1; aw_target_i[0] = 1'b1; aw_len_i[0] = 8'd3;
    cycle();
    idle();
    m_wvalid_i[0] = 1'b1; m_wready_i[0] = 1'b1;
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", 32'(w_valid_o[0]), 0);
    chk("mid_rst_target", 32'(w_target_o[0]), 0);
    chk("mid_rst_err", 32'(len_err_o[0]), 0);
    @(posedge clk); #1;
    idle();
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
